// File: rtl/seven_seg_pkg.sv
// Shared types and hex-to-segment table for the two-digit seven-segment multiplexer.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        BLANK_LO,
        SHOW_LO,
        BLANK_HI,
        SHOW_HI
    } seg_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seven_seg_mux.sv
// Two-digit hex display multiplexer with blanking gaps and frame-aligned updates.
// Optional SEVSEG_LEADING_ZERO_BLANK_EN darkens digit 1 when the high nibble is zero.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 24000000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [6:0] seg_n,
    output logic       digit_sel,
    output logic       frame_done
);

    localparam int unsigned DIV   = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - BLANK_CYCLES - 1);

    if (BLANK_CYCLES == 0 || BLANK_CYCLES >= DIV) begin : g_bad_blank
        $error("seven_seg_mux: BLANK_CYCLES must satisfy 0 < BLANK_CYCLES < DIV");
    end

    seg_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       disp_q, pend_q;
    logic             pend_full_q;
    logic [6:0]       seg_n_q, seg_n_d, dec_seg;
    logic             digit_sel_q, digit_sel_d;
    logic             slot_last, frame_end, accept;
    logic [3:0]       nibble;

    assign slot_last  = (state_q == BLANK_LO || state_q == BLANK_HI) ? (cnt_q == BLANK_LAST)
                                                                     : (cnt_q == SHOW_LAST);
    assign frame_end  = (state_q == SHOW_HI) && slot_last;
    assign accept     = in_valid && !pend_full_q;
    assign in_ready   = !pend_full_q;
    assign frame_done = frame_end;
    assign seg_n      = seg_n_q;
    assign digit_sel  = digit_sel_q;
    assign nibble     = (state_q == SHOW_HI) ? disp_q[7:4] : disp_q[3:0];

    seven_seg_decode u_decode (
        .nibble (nibble),
        .seg_n  (dec_seg)
    );

    always_comb begin
        state_d     = state_q;
        seg_n_d     = SEG_BLANK;
        digit_sel_d = (state_q == BLANK_HI) || (state_q == SHOW_HI);
        unique case (state_q)
            BLANK_LO: state_d = SHOW_LO;
            SHOW_LO: begin
                state_d = BLANK_HI;
                seg_n_d = dec_seg;
            end
            BLANK_HI: state_d = SHOW_HI;
            SHOW_HI: begin
                state_d = BLANK_LO;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
                seg_n_d = (disp_q[7:4] == 4'h0) ? SEG_BLANK : dec_seg;
`else
                seg_n_d = dec_seg;
`endif
            end
            default: state_d = BLANK_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BLANK_LO;
            cnt_q       <= '0;
            seg_n_q     <= SEG_BLANK;
            digit_sel_q <= 1'b0;
            disp_q      <= 8'h00;
            pend_q      <= 8'h00;
            pend_full_q <= 1'b0;
        end else begin
            if (slot_last) begin
                state_q <= state_d;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            seg_n_q     <= seg_n_d;
            digit_sel_q <= digit_sel_d;
            // Accept needs an empty buffer, so it never collides with the boundary transfer.
            if (frame_end && pend_full_q) begin
                disp_q      <= pend_q;
                pend_full_q <= 1'b0;
            end
            if (accept) begin
                pend_q      <= in_data;
                pend_full_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux: directed steps followed by randomized traffic.
module tb_seven_seg_mux;

    localparam int CLK_HZ     = 1000;
    localparam int REFRESH_HZ = 100;
    localparam int BLANK      = 2;
    localparam int DIV        = CLK_HZ / REFRESH_HZ;
    localparam int FRAME      = 2 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [6:0] seg_n;
    logic       digit_sel;
    logic       frame_done;

    seven_seg_mux #(
        .CLK_HZ       (CLK_HZ),
        .REFRESH_HZ   (REFRESH_HZ),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .seg_n      (seg_n),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: position within the frame plus the two data registers.
    int         m_phase;
    logic [7:0] m_disp;
    logic [7:0] m_pend;
    bit         m_pend_full;
    logic [6:0] m_seg;
    bit         m_dsel;
    bit         m_accepted;
    bit         checking;
    logic       prev_dsel;
    int         n_vec;
    int         n_err;

    function automatic logic [6:0] model_seg(input int phase, input logic [7:0] d);
        int digit;
        int off;
        digit = phase / DIV;
        off   = phase % DIV;
        if (off < BLANK) return 7'h7F;
        if (digit == 0) return hex_tab[d[3:0]];
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        if (d[7:4] == 4'h0) return 7'h7F;
`endif
        return hex_tab[d[7:4]];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit was_rst;
        bit acc;
        if (checking) begin
            chk("seg_n", {1'b0, seg_n}, {1'b0, m_seg});
            chk("digit_sel", {7'b0, digit_sel}, {7'b0, m_dsel});
            chk("in_ready", {7'b0, in_ready}, {7'b0, !m_pend_full});
            chk("frame_done", {7'b0, frame_done}, {7'b0, (m_phase == FRAME - 1)});
            if (digit_sel !== prev_dsel) chk("sel_while_lit", {1'b0, seg_n}, 8'h7F);
            prev_dsel = digit_sel;
        end
        was_rst    = rst;
        m_accepted = 1'b0;
        if (rst) begin
            m_phase     = 0;
            m_disp      = 8'h00;
            m_pend_full = 1'b0;
            m_seg       = 7'h7F;
            m_dsel      = 1'b0;
            prev_dsel   = 1'b0;
        end else begin
            acc    = in_valid && !m_pend_full;
            m_seg  = model_seg(m_phase, m_disp);
            m_dsel = (m_phase / DIV) == 1;
            if (m_phase == FRAME - 1 && m_pend_full) begin
                m_disp      = m_pend;
                m_pend_full = 1'b0;
            end
            if (acc) begin
                m_pend      = in_data;
                m_pend_full = 1'b1;
                m_accepted  = 1'b1;
            end
            m_phase = (m_phase + 1) % FRAME;
        end
        @(posedge clk);
        @(negedge clk);
        if (was_rst) checking = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic until_phase(input int p);
        for (int i = 0; i < FRAME && m_phase != p; i++) tick();
    endtask

    task automatic send(input logic [7:0] v);
        int n;
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_accepted && n < 3 * FRAME);
        in_valid = 1'b0;
        n_vec++;
        assert (m_accepted)
        else begin
            n_err++;
            $error("FAIL send_timeout: data %h not accepted within %0d cycles", v, n);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        checking = 1'b0;
        n_vec    = 0;
        n_err    = 0;
        m_pend   = 8'h00;
        @(negedge clk);

        // Reset for three cycles, then idle display of "00"
        run(3);
        rst = 1'b0;
        run(2 * FRAME);

        // Single write mid SHOW_LO
        until_phase(5);
        send(8'h42);
        run(2 * FRAME);

        // Back-to-back writes: second stalls until the boundary
        send(8'h42);
        send(8'h13);
        run(3 * FRAME);

        // Reset during SHOW_HI with a pending value
        until_phase(1);
        send(8'hAB);
        until_phase(15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(2 * FRAME);

        // Leading-zero high digit
        send(8'h05);
        run(3 * FRAME);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            if (in_valid && m_accepted) in_valid = 1'b0;
            if (!in_valid && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        run(FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
